// File: rtl/cost_rom_arbiter.sv
// cost_rom_arbiter
// Round-robin arbiter in front of a single combinational cost-ROM read port.
// A winner is picked combinationally each cycle. Its W/J address is registered
// onto the ROM port, and the returned Cost is captured one cycle later.
// The winner therefore sees its rvalid/rdata two cycles after the grant, and
// the port sustains one new read every cycle.

module cost_rom_arbiter #(
    parameter int N_REQ  = 4,
    parameter int W_BITS = 3,
    parameter int J_BITS = 3,
    parameter int C_BITS = 7
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*W_BITS-1:0]    req_w,
    input  logic [N_REQ*J_BITS-1:0]    req_j,
    output logic [N_REQ-1:0]           gnt,
    output logic [W_BITS-1:0]          W,
    output logic [J_BITS-1:0]          J,
    input  logic [C_BITS-1:0]          Cost,
    output logic [N_REQ-1:0]           rvalid,
    output logic [C_BITS-1:0]          rdata,
    output logic                       busy
);

    // Pointer width, plus one extra bit so that pointer+offset cannot overflow
    // before it is folded back into 0..N_REQ-1.
    localparam int PTR_W = $clog2(N_REQ);
    localparam int SUM_W = PTR_W + 1;
    localparam logic [SUM_W-1:0] N_REQ_L = SUM_W'(N_REQ);

    // Modulo-N_REQ add. Both operands are below N_REQ, so a single
    // conditional subtract is enough.
    function automatic logic [PTR_W-1:0] wrap_add_f(
        input logic [PTR_W-1:0] base,
        input logic [SUM_W-1:0] offs
    );
        logic [SUM_W-1:0] sum;
        sum = {1'b0, base} + offs;
        if (sum >= N_REQ_L) begin
            sum = sum - N_REQ_L;
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    // Requester index to one-hot rvalid vector.
    function automatic logic [N_REQ-1:0] onehot_f(input logic [PTR_W-1:0] id);
        logic [N_REQ-1:0] vec;
        vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            vec[i] = (id == PTR_W'(i));
        end
        return vec;
    endfunction

    // Round-robin pointer, pipeline registers and output registers.
    logic [PTR_W-1:0]   ptr_r;
    logic               s1_valid_r;
    logic [PTR_W-1:0]   s1_id_r;
    logic [W_BITS-1:0]  w_r;
    logic [J_BITS-1:0]  j_r;
    logic [N_REQ-1:0]   rvalid_r;
    logic [C_BITS-1:0]  rdata_r;

    // Combinational arbitration results.
    logic [N_REQ-1:0]   gnt_raw_s;
    logic [N_REQ-1:0]   gnt_s;
    logic               found_s;
    logic [PTR_W-1:0]   idx_s;
    logic [PTR_W-1:0]   gnt_id_s;
    logic [W_BITS-1:0]  w_sel_s;
    logic [J_BITS-1:0]  j_sel_s;
    logic               accept_s;
    logic [PTR_W-1:0]   ptr_nxt_s;

    // Scan requests starting at the pointer and grant the first active one.
    always_comb begin
        gnt_raw_s = '0;
        found_s   = 1'b0;
        idx_s     = '0;
        for (int o = 0; o < N_REQ; o++) begin
            idx_s = wrap_add_f(ptr_r, SUM_W'(o));
            if (!found_s && req[idx_s]) begin
                gnt_raw_s[idx_s] = 1'b1;
                found_s          = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // No grant may be issued while reset is asserted.
    assign gnt_s = RST ? gnt_raw_s : '0;
    assign gnt   = gnt_s;

    // Encode the winner and select its address from the packed request buses.
    always_comb begin
        gnt_id_s = '0;
        w_sel_s  = '0;
        j_sel_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_s[i]) begin
                gnt_id_s = PTR_W'(i);
                w_sel_s  = req_w[i*W_BITS +: W_BITS];
                j_sel_s  = req_j[i*J_BITS +: J_BITS];
            end else begin
                gnt_id_s = gnt_id_s;
                w_sel_s  = w_sel_s;
                j_sel_s  = j_sel_s;
            end
        end
    end

    assign accept_s  = |gnt_s;
    assign ptr_nxt_s = wrap_add_f(gnt_id_s, SUM_W'(1));

    // Pointer and stage-1 address registers. On an idle cycle W/J keep their
    // previous value so that the ROM address lines do not toggle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ptr_r      <= '0;
            s1_valid_r <= 1'b0;
            s1_id_r    <= '0;
            w_r        <= '0;
            j_r        <= '0;
        end else if (accept_s) begin
            ptr_r      <= ptr_nxt_s;
            s1_valid_r <= 1'b1;
            s1_id_r    <= gnt_id_s;
            w_r        <= w_sel_s;
            j_r        <= j_sel_s;
        end else begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2 captures the ROM data and pulses rvalid for the owning requester.
    // Reads still in flight are dropped by reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rvalid_r <= '0;
            rdata_r  <= '0;
        end else if (s1_valid_r) begin
            rvalid_r <= onehot_f(s1_id_r);
            rdata_r  <= Cost;
        end else begin
            rvalid_r <= '0;
        end
    end

    assign W      = w_r;
    assign J      = j_r;
    assign rvalid = rvalid_r;
    assign rdata  = rdata_r;
    assign busy   = s1_valid_r | (|rvalid_r);

endmodule

// File: tb/tb_cost_rom_arbiter.sv
// Directed bench for cost_rom_arbiter. A behavioural cost ROM is modelled as
// cost(a) = (a*37 + 11) mod 128 with a = {W,J}.
// Expected costs are worked out by hand:
// cost(0)=11, cost(10)=125, cost(19)=74, cost(29)=60, cost(38)=9,
// cost(41)=120, cost(50)=69, cost(63)=38.

module tb_cost_rom_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  req;
    logic [11:0] req_w;
    logic [11:0] req_j;
    logic [3:0]  gnt;
    logic [2:0]  W;
    logic [2:0]  J;
    logic [6:0]  Cost;
    logic [3:0]  rvalid;
    logic [6:0]  rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    cost_rom_arbiter #(.N_REQ(4), .W_BITS(3), .J_BITS(3), .C_BITS(7)) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_w(req_w), .req_j(req_j),
        .gnt(gnt), .W(W), .J(J), .Cost(Cost), .rvalid(rvalid),
        .rdata(rdata), .busy(busy)
    );

    function automatic logic [6:0] rom_f(input logic [5:0] a);
        int v;
        v = int'(a) * 37 + 11;
        return 7'(v % 128);
    endfunction

    assign Cost = rom_f({W, J});

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [2:0] w, input logic [2:0] j);
        req_w[i*3 +: 3] = w;
        req_j[i*3 +: 3] = j;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0; req = 4'b0000; req_w = 12'h000; req_j = 12'h000;
        tick(); tick();
        // reset state, grant suppressed while in reset
        chk("rst_W", 32'(W), 32'd0);
        chk("rst_J", 32'(J), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req = 4'b1111; #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        req = 4'b0000;

        // single request: requester 0, w=3 j=5 -> addr 29
        RST = 1'b1;
        set_addr(0, 3'd3, 3'd5);
        req = 4'b0001; #1;
        chk("single_gnt", 32'(gnt), 32'b0001);
        tick(); req = 4'b0000; #1;
        chk("single_W", 32'(W), 32'd3);
        chk("single_J", 32'(J), 32'd5);
        chk("single_rv_t1", 32'(rvalid), 32'd0);
        chk("single_busy_t1", 32'(busy), 32'd1);
        tick();
        chk("single_rvalid", 32'(rvalid), 32'b0001);
        chk("single_rdata", 32'(rdata), 32'd60);
        chk("single_busy_t2", 32'(busy), 32'd1);
        tick();
        chk("single_rv_t3", 32'(rvalid), 32'd0);
        chk("single_busy_t3", 32'(busy), 32'd0);

        // all four requesting continuously from reset
        RST = 1'b0; tick(); RST = 1'b1;
        set_addr(0, 3'd1, 3'd2);
        set_addr(1, 3'd2, 3'd3);
        set_addr(2, 3'd4, 3'd6);
        set_addr(3, 3'd7, 3'd7);
        req = 4'b1111; #1;
        chk("all_gnt0", 32'(gnt), 32'b0001);
        tick();
        chk("all_gnt1", 32'(gnt), 32'b0010);
        chk("all_W0", 32'(W), 32'd1);
        chk("all_J0", 32'(J), 32'd2);
        tick();
        chk("all_gnt2", 32'(gnt), 32'b0100);
        chk("all_rv0", 32'(rvalid), 32'b0001);
        chk("all_rd0", 32'(rdata), 32'd125);
        tick();
        chk("all_gnt3", 32'(gnt), 32'b1000);
        chk("all_rv1", 32'(rvalid), 32'b0010);
        chk("all_rd1", 32'(rdata), 32'd74);
        tick();
        chk("all_gnt4", 32'(gnt), 32'b0001);
        chk("all_rv2", 32'(rvalid), 32'b0100);
        chk("all_rd2", 32'(rdata), 32'd9);
        tick(); req = 4'b0000; #1;
        chk("all_rv3", 32'(rvalid), 32'b1000);
        chk("all_rd3", 32'(rdata), 32'd38);
        tick();
        chk("all_rv4", 32'(rvalid), 32'b0001);
        chk("all_rd4", 32'(rdata), 32'd125);
        tick();
        chk("all_idle_rv", 32'(rvalid), 32'd0);
        chk("all_idle_busy", 32'(busy), 32'd0);

        // pointer fairness: ptr=1, grant 2, then 1001 goes to 3 before 0
        req = 4'b0100; #1;
        chk("fair_gnt2", 32'(gnt), 32'b0100);
        tick(); req = 4'b1001; #1;
        chk("fair_gnt3", 32'(gnt), 32'b1000);
        tick(); req = 4'b0001; #1;
        chk("fair_gnt0", 32'(gnt), 32'b0001);
        chk("fair_rv2", 32'(rvalid), 32'b0100);
        chk("fair_rd2", 32'(rdata), 32'd9);
        tick(); req = 4'b0000; #1;
        chk("fair_rv3", 32'(rvalid), 32'b1000);
        chk("fair_rd3", 32'(rdata), 32'd38);
        tick();
        chk("fair_rv0", 32'(rvalid), 32'b0001);
        chk("fair_rd0", 32'(rdata), 32'd125);

        // boundary address w=0 j=0 (ptr=1)
        set_addr(1, 3'd0, 3'd0);
        req = 4'b0010; #1;
        chk("zero_gnt", 32'(gnt), 32'b0010);
        tick(); req = 4'b0000; #1;
        chk("zero_W", 32'(W), 32'd0);
        chk("zero_J", 32'(J), 32'd0);
        tick();
        chk("zero_rv", 32'(rvalid), 32'b0010);
        chk("zero_rd", 32'(rdata), 32'd11);
        tick();

        // reset mid-flight (ptr=2): requester 2 w=5 j=1
        set_addr(2, 3'd5, 3'd1);
        req = 4'b0100; #1;
        chk("mid_gnt", 32'(gnt), 32'b0100);
        tick(); req = 4'b0000; RST = 1'b0; #1;
        chk("mid_W", 32'(W), 32'd5);
        chk("mid_J", 32'(J), 32'd1);
        tick();
        chk("mid_rv", 32'(rvalid), 32'd0);
        chk("mid_rd", 32'(rdata), 32'd0);
        chk("mid_Wrst", 32'(W), 32'd0);
        chk("mid_Jrst", 32'(J), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        RST = 1'b1;
        req = 4'b1100; #1;
        chk("mid_gnt_after", 32'(gnt), 32'b0100);
        tick(); req = 4'b0000; #1;
        tick();
        chk("mid_rv_after", 32'(rvalid), 32'b0100);
        chk("mid_rd_after", 32'(rdata), 32'd120);
        tick();

        // withdrawal (ptr=3): requester 1 drops while requester 0 wins
        set_addr(0, 3'd6, 3'd2);
        set_addr(1, 3'd3, 3'd1);
        req = 4'b0011; #1;
        chk("wd_gnt_a", 32'(gnt), 32'b0001);
        req = 4'b0001; #1;
        chk("wd_gnt_b", 32'(gnt), 32'b0001);
        tick(); req = 4'b0000; #1;
        chk("wd_gnt_idle", 32'(gnt), 32'd0);
        chk("wd_W", 32'(W), 32'd6);
        chk("wd_J", 32'(J), 32'd2);
        tick();
        chk("wd_rv", 32'(rvalid), 32'b0001);
        chk("wd_rd", 32'(rdata), 32'd69);
        tick();
        chk("wd_rv_idle", 32'(rvalid), 32'd0);
        chk("wd_busy_idle", 32'(busy), 32'd0);
        tick();
        chk("wd_W_hold", 32'(W), 32'd6);
        chk("wd_J_hold", 32'(J), 32'd2);
        chk("wd_rv_idle2", 32'(rvalid), 32'd0);

        // simultaneous withdrawal (ptr=1): requester 1 drops, next in order wins
        req = 4'b0110; #1;
        chk("sim_gnt_a", 32'(gnt), 32'b0010);
        req = 4'b0100; #1;
        chk("sim_gnt_b", 32'(gnt), 32'b0100);
        tick(); req = 4'b0000; #1;
        chk("sim_W", 32'(W), 32'd5);
        chk("sim_J", 32'(J), 32'd1);
        tick();
        chk("sim_rv", 32'(rvalid), 32'b0100);
        chk("sim_rd", 32'(rdata), 32'd120);
        tick();
        chk("sim_rv_idle", 32'(rvalid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
